canvas_port_ctrl: RTL
=====================

Name: canvas_port_ctrl

Overview:
Sequences and shares canvas port B between two requesters. The first is a CPU/bus single-cell read/write channel. The second is an internal rectangle-fill engine that writes one colour into a rectangular cell region. Port A stays with video scan-out; this block owns web/colb/rowb/dib and consumes dob.

Parameters:
COLS, 336, canvas width in cells; column index range 0..COLS-1
ROWS, 256, canvas height in cells; row index range 0..ROWS-1

Ports:
clk  in  1  canvas port-B clock (same clock as the canvas clkb)
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request; held high until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
cpu_col  in  9  CPU cell column
cpu_row  in  8  CPU cell row
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  read data; valid in the cpu_ack cycle of a read, held until the next read completes
fill_start  in  1  one-cycle pulse that launches a fill
fill_col0  in  9  top-left column of the rectangle
fill_row0  in  8  top-left row of the rectangle
fill_w  in  9  width in cells (0..336)
fill_h  in  9  height in cells (0..256)
fill_color  in  8  fill byte
fill_busy  out  1  high while a fill is active
fill_done  out  1  one-cycle pulse at fill completion
web  out  1  canvas port-B write enable
colb  out  9  canvas port-B column
rowb  out  8  canvas port-B row
dib  out  8  canvas port-B write data
dob  in  8  canvas port-B read data (registered; valid one clk after address issued with web=0)

Behaviour:
- Reset: all outputs are registered and reset to 0. An asynchronous reset during a fill aborts the fill; no fill_done is generated. A pending CPU request is dropped; the CPU must re-request after reset.
- Port slot: one canvas access per cycle. The address, web and dib values registered at edge N perform their BRAM access at edge N+1. web=0 in every cycle with no write; idle cycles hold colb/rowb.
- CPU write: request sampled at edge N is granted. web=1, col, row and data are registered at N. cpu_ack pulses in cycle N+1.
- CPU read: request granted at edge N with web=0. dob is valid after N+1. cpu_rdata is captured at N+2, and cpu_ack pulses in cycle N+2. No new CPU grant is issued until the ack, so there is one outstanding CPU access at most.
- CPU req still high in the cycle after cpu_ack counts as a new request.
- Fill launch: fill_start sampled with fill_busy=0 latches all fill_* inputs, and fill_busy rises the next cycle. fill_start while busy is ignored. fill_start in the same cycle as fill_done is also ignored.
- Zero size: fill_w=0 or fill_h=0 gives one busy cycle, no writes, then a fill_done pulse.
- Fill order: row-major. Columns run col0..col0+w-1 within a row, then the row advances. Counters are 10 bits wide so there is no wrap.
- Clipping: a cell with col ≥ COLS or row ≥ ROWS still consumes its slot but issues web=0. No wrap-around into other rows.
- fill_done pulses in the cycle after the last cell's slot. fill_busy falls in the same cycle as fill_done.
- Arbitration (fill active):
  - The CPU has priority for a grant.
  - After any CPU grant, the fill gets the next free slot before another CPU grant, which guarantees alternation.
  - The fill pauses (position held) in any cycle the port serves the CPU.
  - A CPU read occupies one slot only; its return cycle is free for the fill.
- Simultaneous cpu_req and fill_start while idle: the CPU is granted in that cycle; the fill latches and starts on the following slot.
- States: IDLE, FILL, DONE.
  - IDLE→FILL on accepted start with nonzero size.
  - IDLE→DONE on zero size.
  - FILL→DONE after the last cell.
  - DONE→IDLE unconditionally.
  - A CPU-read tracker runs alongside as a 2-stage valid pipe.

Test Plan:
- CPU write col=5,row=7,data=0xA5, then CPU read of the same cell -> web=1,colb=5,rowb=7,dib=0xA5; write ack 1 cycle after grant; read returns cpu_rdata=0xA5 with ack 2 cycles after grant.
- Fill col0=10,row0=20,w=3,h=2,color=0x3C, no CPU traffic -> exactly 6 writes in order (10,20)(11,20)(12,20)(10,21)(11,21)(12,21); fill_done 1 cycle after the 6th slot; busy for 7 cycles.
- Fill col0=334,row0=255,w=4,h=2 -> writes only to (334,255) and (335,255); other slots have web=0; busy spans 8 slots plus done.
- Fill w=100,h=1 with cpu_req held high continuously for reads -> slots alternate CPU/fill; all 100 fill writes occur; every read returns the correct data.
- fill_w=0 -> no web pulses; fill_done 1 cycle after busy rises; a second fill_start while busy is ignored (write count is unchanged).
- rst_n low mid-fill at cell 3 of 6 -> outputs 0 immediately; no fill_done; cells 4-6 unwritten; new fill accepted after release.

Source files
------------

// File: rtl/canvas_port_ctrl_if.sv
// Canvas port-B sharing bundle: CPU single-cell channel, rectangle-fill
// launch/status, and the port-B BRAM pins driven by the controller.
interface canvas_port_ctrl_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [8:0] cpu_col;
  logic [7:0] cpu_row;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;

  logic       fill_start;
  logic [8:0] fill_col0;
  logic [7:0] fill_row0;
  logic [8:0] fill_w;
  logic [8:0] fill_h;
  logic [7:0] fill_color;
  logic       fill_busy;
  logic       fill_done;

  logic       web;
  logic [8:0] colb;
  logic [7:0] rowb;
  logic [7:0] dib;
  logic [7:0] dob;

  modport slave (
    input  cpu_req, cpu_we, cpu_col, cpu_row, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  fill_start, fill_col0, fill_row0, fill_w, fill_h, fill_color,
    output fill_busy, fill_done,
    output web, colb, rowb, dib,
    input  dob
  );

  modport master (
    output cpu_req, cpu_we, cpu_col, cpu_row, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output fill_start, fill_col0, fill_row0, fill_w, fill_h, fill_color,
    input  fill_busy, fill_done,
    input  web, colb, rowb, dib,
    output dob
  );
endinterface

// File: rtl/canvas_port_ctrl.sv
// Canvas port-B controller: one access per cycle, shared between a CPU
// single-cell read/write channel (priority) and a row-major rectangle fill.
// The fill yields whenever the CPU is granted and always gets the slot after
// a CPU grant; out-of-canvas cells burn their slot with web=0.
module canvas_port_ctrl #(
  parameter int COLS = 336,
  parameter int ROWS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  canvas_port_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t     state, state_n;

  logic [8:0] col0_q;
  logic [7:0] color_q;
  logic [9:0] col_end_q;
  logic [9:0] row_end_q;
  logic [9:0] x_q;
  logic [9:0] y_q;
  logic [9:0] x_nx;
  logic [9:0] y_nx;

  logic       wr_vld_p0;
  logic       rd_vld_p0;
  logic       rd_vld_p1;
  logic       owed;

  logic       size_zero;
  logic       accept;
  logic       cpu_block;
  logic       cpu_grant;
  logic       fill_slot;
  logic       last_cell;
  logic       in_range;

  assign size_zero = (bus.fill_w == 9'd0) || (bus.fill_h == 9'd0);
  assign x_nx      = x_q + 10'd1;
  assign y_nx      = y_q + 10'd1;
  assign last_cell = (x_nx == col_end_q) && (y_nx == row_end_q);
  assign in_range  = (x_q < 10'(COLS)) && (y_q < 10'(ROWS));
  // One CPU access in flight; the ack cycle itself still belongs to the old request.
  assign cpu_block = wr_vld_p0 | rd_vld_p0 | rd_vld_p1 | bus.cpu_ack;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state plus slot decision: CPU first unless the fill is owed a slot
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    cpu_grant = 1'b0;
    fill_slot = 1'b0;
    accept    = (state == IDLE) && bus.fill_start && !bus.fill_done;
    cpu_grant = bus.cpu_req && !cpu_block && !((state == FILL) && owed);
    fill_slot = (state == FILL) && !cpu_grant;
    case (state)
      IDLE:    if (accept) state_n = size_zero ? DONE : FILL;
      FILL:    if (fill_slot && last_cell) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Fill status flags: busy covers the accepted start through the last slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fill_busy <= 1'b0;
      bus.fill_done <= 1'b0;
      owed          <= 1'b0;
    end else begin
      bus.fill_busy <= (state_n != IDLE);
      bus.fill_done <= (state == DONE);
      if (cpu_grant)                          owed <= 1'b1;
      else if (fill_slot || state_n == IDLE)  owed <= 1'b0;
    end
  end

  // Port-B slot register: CPU grant, else the current fill cell, else no write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.web  <= 1'b0;
      bus.colb <= 9'd0;
      bus.rowb <= 8'd0;
      bus.dib  <= 8'd0;
    end else if (cpu_grant) begin
      bus.web  <= bus.cpu_we;
      bus.colb <= bus.cpu_col;
      bus.rowb <= bus.cpu_row;
      if (bus.cpu_we) bus.dib <= bus.cpu_wdata;
    end else if (fill_slot) begin
      bus.web  <= in_range;
      bus.colb <= x_q[8:0];
      bus.rowb <= y_q[7:0];
      bus.dib  <= color_q;
    end else begin
      bus.web  <= 1'b0;
    end
  end

  // CPU completion tracker: write acks after one stage, read after two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_p0     <= 1'b0;
      rd_vld_p0     <= 1'b0;
      rd_vld_p1     <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= 8'd0;
    end else begin
      wr_vld_p0   <= cpu_grant && bus.cpu_we;
      rd_vld_p0   <= cpu_grant && !bus.cpu_we;
      rd_vld_p1   <= rd_vld_p0;
      bus.cpu_ack <= wr_vld_p0 | rd_vld_p1;
      if (rd_vld_p1) bus.cpu_rdata <= bus.dob;
    end
  end

  // Fill walker: latch the rectangle on accept, step row-major on each fill slot
  always_ff @(posedge clk) begin
    if (accept) begin
      col0_q    <= bus.fill_col0;
      color_q   <= bus.fill_color;
      col_end_q <= {1'b0, bus.fill_col0} + {1'b0, bus.fill_w};
      row_end_q <= {2'b00, bus.fill_row0} + {1'b0, bus.fill_h};
      x_q       <= {1'b0, bus.fill_col0};
      y_q       <= {2'b00, bus.fill_row0};
    end else if (fill_slot) begin
      if (x_nx == col_end_q) begin
        x_q <= {1'b0, col0_q};
        y_q <= y_nx;
      end else begin
        x_q <= x_nx;
      end
    end
  end

endmodule
